// File: rtl/display_scan.sv
// display_scan: time-multiplexed 7-segment scan controller.
// Walks NUM_DIGITS digits. Each digit slot has a guard interval with all anodes
// off, followed by a lit interval. Digit content is double-buffered. A new
// load waits in the pending buffer until the next frame boundary.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module display_scan #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned GUARD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [3:0]              q,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int unsigned CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {
    ST_GUARD = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [4*NUM_DIGITS-1:0] act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_valid_q, pend_valid_d;

  logic [3:0]              q_q, q_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    dp_q, dp_d;
  logic                    fd_q, fd_d;

  logic                    slot_end;
  logic                    wrap;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [NUM_DIGITS-1:0]   blank_vec;

  assign slot_end = (state_q == ST_GUARD) ? (cnt_q == GUARD_LAST) : (cnt_q == REFRESH_LAST);
  assign wrap     = (state_q == ST_SHOW) && slot_end && (idx_q == IDX_LAST);

  // State register: phase, digit index and slot counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_GUARD;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: guard -> show -> guard of the next digit, with the counter
  // restarting at every phase change.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CNT_W'(1);
    if (slot_end) begin
      cnt_d = '0;
      if (state_q == ST_GUARD) begin
        state_d = ST_SHOW;
      end else begin
        state_d = ST_GUARD;
        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
    end
  end

  // Buffer registers: the active buffer is displayed and the pending buffer is
  // the most recent load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_dig_q    <= '0;
      act_blank_q  <= '0;
      act_dp_q     <= '0;
      pend_dig_q   <= '0;
      pend_blank_q <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      act_dig_q    <= act_dig_d;
      act_blank_q  <= act_blank_d;
      act_dp_q     <= act_dp_d;
      pend_dig_q   <= pend_dig_d;
      pend_blank_q <= pend_blank_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  // Buffer update. Pending moves to active only on the frame wrap. A load on
  // the same cycle is applied after the transfer, so it waits for the next
  // frame boundary.
  always_comb begin
    act_dig_d    = act_dig_q;
    act_blank_d  = act_blank_q;
    act_dp_d     = act_dp_q;
    pend_dig_d   = pend_dig_q;
    pend_blank_d = pend_blank_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    if (wrap && pend_valid_q) begin
      act_dig_d    = pend_dig_q;
      act_blank_d  = pend_blank_q;
      act_dp_d     = pend_dp_q;
      pend_valid_d = 1'b0;
    end
    if (load) begin
      pend_dig_d   = digits_in;
      pend_blank_d = blank_mask;
      pend_dp_d    = dp_mask;
      pend_valid_d = 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic zero_above;

  // Leading-zero blanking. Scan from the top digit downward while every digit
  // seen so far is zero. Digit 0 is always exempt.
  always_comb begin
    zero_above = 1'b1;
    lz_blank   = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      zero_above = zero_above & (act_dig_d[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
      if (k != NUM_DIGITS - 1) lz_blank[NUM_DIGITS-1-k] = zero_above;
    end
  end
`else
  assign lz_blank = '0;
`endif

  // Per-digit blank decision from the active buffer: mask bit, reserved
  // codes 13/15, or leading zero.
  always_comb begin
    blank_vec = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      blank_vec[i] = act_blank_d[i] | lz_blank[i]
                   | (act_dig_d[4*i +: 4] == 4'd13)
                   | (act_dig_d[4*i +: 4] == 4'd15);
    end
  end

  // Output decode. It uses next-state values so the registered outputs line up
  // with the registered state. q changes only on guard entry.
  always_comb begin
    q_d  = q_q;
    an_d = '1;
    dp_d = 1'b1;
    fd_d = wrap;
    if ((state_q == ST_SHOW) && slot_end) begin
      q_d = act_dig_d[{idx_d, 2'b00} +: 4];
    end
    if ((state_d == ST_SHOW) && !blank_vec[idx_d]) begin
      an_d[idx_d] = 1'b0;
      dp_d        = ~act_dp_d[idx_d];
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q  <= '0;
      an_q <= '1;
      dp_q <= 1'b1;
      fd_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      an_q <= an_d;
      dp_q <= dp_d;
      fd_q <= fd_d;
    end
  end

  assign q          = q_q;
  assign an         = an_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

  // Safety: never more than one anode on, and none during a guard interval.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert ($onehot0(~an_q));
      if (state_q == ST_GUARD) assert (an_q == '1);
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Testbench for display_scan (NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=2).
// The frame model works from the position in the 24-cycle frame.
// Directed checks use hand-computed constants.
module tb_display_scan;

  localparam int N = 4;
  localparam int R = 4;
  localparam int G = 2;
  localparam int SLOT = G + R;
  localparam int FRAME = N * SLOT;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB_EN = 1'b1;
`else
  localparam bit LZB_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   digits_in = '0;
  logic          load = 1'b0;
  logic [3:0]    blank_mask = '0;
  logic [3:0]    dp_mask = '0;
  logic [3:0]    q;
  logic [3:0]    an;
  logic          dp;
  logic          frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  display_scan #(.NUM_DIGITS(N), .REFRESH_DIV(R), .GUARD_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .load(load),
    .blank_mask(blank_mask), .dp_mask(dp_mask),
    .q(q), .an(an), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: edges since reset, plus the active and pending buffers.
  int          mt;
  logic [15:0] m_act_dig, m_pend_dig;
  logic [3:0]  m_act_bl, m_pend_bl, m_act_dp, m_pend_dp;
  logic        m_pv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mt <= 0;
      m_act_dig <= '0; m_act_bl <= '0; m_act_dp <= '0;
      m_pend_dig <= '0; m_pend_bl <= '0; m_pend_dp <= '0;
      m_pv <= 1'b0;
    end else begin
      mt <= mt + 1;
      if (((mt + 1) % FRAME == 0) && m_pv) begin
        m_act_dig <= m_pend_dig;
        m_act_bl  <= m_pend_bl;
        m_act_dp  <= m_pend_dp;
      end
      if (load) begin
        m_pend_dig <= digits_in;
        m_pend_bl  <= blank_mask;
        m_pend_dp  <= dp_mask;
        m_pv       <= 1'b1;
      end else if ((mt + 1) % FRAME == 0) begin
        m_pv <= 1'b0;
      end
    end
  end

  function automatic bit lz_rule(input logic [15:0] dig, input int i);
    int h = 0;
    logic [3:0] c;
    for (int k = 0; k < N; k++) begin
      c = dig[k*4 +: 4];
      if (c != 4'd0) h = k;
    end
    c = dig[i*4 +: 4];
    return LZB_EN && (i > h) && (c == 4'd0);
  endfunction

  // Compare process: checks every output on every negedge out of reset.
  int         p, d, ph;
  logic [3:0] e_code, e_an;
  logic       e_dp, e_fd, e_blank;
  always @(negedge clk) begin
    if (rst_n) begin
      p  = mt % FRAME;
      d  = p / SLOT;
      ph = p % SLOT;
      e_code  = m_act_dig[d*4 +: 4];
      e_blank = m_act_bl[d] || (e_code == 4'd13) || (e_code == 4'd15) || lz_rule(m_act_dig, d);
      e_an = 4'hF;
      e_dp = 1'b1;
      if (ph >= G && !e_blank) begin
        e_an[d] = 1'b0;
        e_dp    = ~m_act_dp[d];
      end
      e_fd = (p == 0) && (mt > 0);
      check("model_q", {28'd0, q}, {28'd0, e_code});
      check("model_an", {28'd0, an}, {28'd0, e_an});
      check("model_dp", {31'd0, dp}, {31'd0, e_dp});
      check("model_frame_done", {31'd0, frame_done}, {31'd0, e_fd});
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] dv, input logic [3:0] bm, input logic [3:0] dm);
    digits_in  = dv;
    blank_mask = bm;
    dp_mask    = dm;
    load       = 1'b1;
    @(negedge clk);
    load       = 1'b0;
  endtask

  task automatic wait_frame(input string name, input int exp_n);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 100);
    check(name, n, exp_n);
  endtask

  logic [3:0] seen_low;
  logic [3:0] x_an;
  logic       x_dp;

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_an", {28'd0, an}, 32'hF);
    check("rst_q", {28'd0, q}, 32'h0);
    check("rst_dp", {31'd0, dp}, 32'h1);
    check("rst_fd", {31'd0, frame_done}, 32'h0);
    #1 rst_n = 1'b1;

    // Basic scan of 4321.
    do_load(16'h4321, 4'b0000, 4'b0000);               // p=1
    wait_frame("first_boundary", 23);                  // p=0
    check("f1_q_guard", {28'd0, q}, 32'h1);
    check("f1_an_guard", {28'd0, an}, 32'hF);
    wait_cycles(2);                                    // p=2
    check("d0_an", {28'd0, an}, 32'hE);
    check("d0_q", {28'd0, q}, 32'h1);
    wait_cycles(6);                                    // p=8
    check("d1_an", {28'd0, an}, 32'hD);
    check("d1_q", {28'd0, q}, 32'h2);
    wait_frame("frame_period", 16);                    // p=0

    // Two loads in the middle of digit 2; the last load wins, next frame.
    wait_cycles(13);                                   // p=13
    do_load(16'h1111, 4'b0000, 4'b0000);               // p=14
    do_load(16'h5678, 4'b0000, 4'b0000);               // p=15
    check("mid_d2_q", {28'd0, q}, 32'h3);
    check("mid_d2_an", {28'd0, an}, 32'hB);
    wait_cycles(5);                                    // p=20
    check("mid_d3_q", {28'd0, q}, 32'h4);
    check("mid_d3_an", {28'd0, an}, 32'h7);
    wait_frame("swap_boundary", 4);                    // p=0
    check("swap_q", {28'd0, q}, 32'h8);
    wait_cycles(2);                                    // p=2
    check("swap_d0_an", {28'd0, an}, 32'hE);
    check("swap_d0_q", {28'd0, q}, 32'h8);

    // Blank mask on digit 2, code D on digit 3, decimal point on digit 1.
    do_load(16'hD678, 4'b0100, 4'b0010);               // p=3
    wait_frame("blank_boundary", 21);                  // p=0
    for (int i = 0; i < FRAME; i++) begin
      x_an = 4'hF;
      x_dp = 1'b1;
      if (i >= 2 && i < 6) x_an = 4'hE;
      if (i >= 8 && i < 12) begin
        x_an = 4'hD;
        x_dp = 1'b0;
      end
      check("blank_an", {28'd0, an}, {28'd0, x_an});
      check("blank_dp", {31'd0, dp}, {31'd0, x_dp});
      wait_cycles(1);
    end
    check("blank_frame_len", {31'd0, frame_done}, 32'h1);

    // Leading-zero behaviour on 0070.
    do_load(16'h0070, 4'b0000, 4'b0000);               // p=1
    wait_frame("lz_boundary", 23);                     // p=0
    seen_low = '0;
    for (int i = 0; i < FRAME; i++) begin
      seen_low = seen_low | ~an;
      if (i == 2) begin
        check("lz_d0_an", {28'd0, an}, 32'hE);
        check("lz_d0_q", {28'd0, q}, 32'h0);
      end
      wait_cycles(1);
    end
    check("lz_seen", {28'd0, seen_low}, LZB_EN ? 32'h3 : 32'hF);

    // Asynchronous reset in the middle of a lit interval.
    wait_cycles(3);                                    // p=3, digit 0 lit
    check("pre_rst_an", {28'd0, an}, 32'hE);
    #2 rst_n = 1'b0;
    #1;
    check("async_an", {28'd0, an}, 32'hF);
    check("async_q", {28'd0, q}, 32'h0);
    check("async_dp", {31'd0, dp}, 32'h1);
    check("async_fd", {31'd0, frame_done}, 32'h0);
    wait_cycles(2);
    #1 rst_n = 1'b1;
    wait_cycles(2);                                    // p=2
    check("post_rst_an", {28'd0, an}, 32'hE);
    check("post_rst_q", {28'd0, q}, 32'h0);
    wait_frame("post_rst_frame", 22);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
